// File: rtl/apb3_pkg.sv
// Shared constants for the APB3 master bridge: FSM encoding, default widths and
// the wait-timer width.
package apb3_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned TMR_W      = 16;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

endpackage

// File: rtl/apb3_wait_timer.sv
// Counts ACCESS cycles spent waiting on PREADY and flags the cycle on which the
// wait limit is reached.
module apb3_wait_timer
    import apb3_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    logic [TMR_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (tick && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the waiting cycle that would bring the count up to LIMIT.
    assign expired = tick && ((32'(cnt_q) + 32'd1) >= LIMIT);

endmodule

// File: rtl/apb3_master_bridge.sv
// Single-outstanding APB3 initiator: command channel in, SETUP/ACCESS on APB, response out.
// Optional access-phase wait abort is enabled with the APB_TIMEOUT_EN macro.
module apb3_master_bridge
    import apb3_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    logic [1:0]        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
    apb3_wait_timer #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (clk_i),
        .rst     (rst_i),
        .clear   (state_q == StSetup),
        .tick    ((state_q == StAccess) && !PREADY),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                // PREADY on the limit cycle still completes normally.
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = StResp;
                end else if (timeout_hit) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Randomized bench for apb3_master_bridge against a transaction-level model, plus directed
// scenarios with literal expectations. Honours APB_TIMEOUT_EN when defined.
module tb_apb3_master_bridge;

    localparam int TCYC = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: one transfer in flight, tracked by its age and wait count.
    bit          m_busy, m_has_rsp;
    int          m_age, m_waits;
    logic        m_wr;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_err, m_to;

    always #5 clk = ~clk;

    apb3_master_bridge #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic model_update();
        if (rst_i) begin
            m_busy = 0; m_has_rsp = 0; m_age = 0; m_waits = 0;
            m_wr = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_err = 0; m_to = 0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1; m_has_rsp = 0; m_age = 1; m_waits = 0;
                m_wr = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
            end
        end else if (!m_has_rsp) begin
            if (m_age == 1) begin
                m_age = 2;
            end else if (PREADY) begin
                m_has_rsp = 1;
                m_rdata = m_wr ? 32'h0 : PRDATA;
                m_err = PSLVERR;
                m_to = 0;
            end else begin
                m_waits++;
`ifdef APB_TIMEOUT_EN
                if (m_waits == TCYC) begin
                    m_has_rsp = 1; m_rdata = 0; m_err = 1; m_to = 1;
                end
`endif
            end
        end else if (rsp_ready) begin
            m_busy = 0; m_has_rsp = 0;
        end
    endtask

    task automatic compare();
        chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, !m_busy});
        chk("psel", {31'b0, PSEL}, {31'b0, m_busy && !m_has_rsp});
        chk("penable", {31'b0, PENABLE}, {31'b0, m_busy && !m_has_rsp && m_age >= 2});
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_has_rsp});
        chk("paddr", PADDR, m_addr);
        chk("pwrite", {31'b0, PWRITE}, {31'b0, m_wr});
        chk("pwdata", PWDATA, m_wdata);
        if (m_has_rsp) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_err});
            chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, m_to});
        end
`ifndef APB_TIMEOUT_EN
        chk("rsp_timeout_tied", {31'b0, rsp_timeout}, 32'h0);
`endif
    endtask

    task automatic step(input logic cv, input logic cw, input logic [31:0] ca,
                        input logic [31:0] cd, input logic pr, input logic [31:0] prd,
                        input logic perr, input logic rr, input logic r);
        cmd_valid = cv; cmd_write = cw; cmd_addr = ca; cmd_wdata = cd;
        PREADY = pr; PRDATA = prd; PSLVERR = perr; rsp_ready = rr; rst_i = r;
        @(posedge clk);
        #1;
        model_update();
        compare();
    endtask

    task automatic idle(input logic pr, input logic rr);
        step(1'b0, 1'b0, 32'h0, 32'h0, pr, 32'hdead_beef, 1'b1, rr, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
        chk("rst_psel", {31'b0, PSEL}, 32'h0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_rsp", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);

        // Zero-wait write.
        step(1'b1, 1'b1, 32'h3000_0100, 32'h1, 1'b1, 32'h55, 1'b0, 1'b1, 1'b0);
        chk("w_setup_psel", {30'b0, PSEL, PENABLE}, 32'h2);
        chk("w_setup_pwrite", {31'b0, PWRITE}, 32'h1);
        chk("w_setup_pwdata", PWDATA, 32'h1);
        chk("w_setup_paddr", PADDR, 32'h3000_0100);
        step(1'b0, 1'b0, 0, 0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        chk("w_access", {30'b0, PSEL, PENABLE}, 32'h3);
        step(1'b0, 1'b0, 0, 0, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        chk("w_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        chk("w_rsp_rdata", rsp_rdata, 32'h0);
        chk("w_rsp_err", {31'b0, rsp_err}, 32'h0);
        idle(1'b0, 1'b1);
        chk("w_done_ready", {31'b0, cmd_ready}, 32'h1);

        // Read with three wait cycles.
        step(1'b1, 1'b0, 32'h3000_0004, 32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 0, 0, 1'b0, 32'hffff_ffff, 1'b1, 1'b0, 1'b0);
            chk("r_wait_addr", PADDR, 32'h3000_0004);
            chk("r_wait_sel", {30'b0, PSEL, PENABLE}, 32'h3);
        end
        step(1'b0, 1'b0, 0, 0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        chk("r_rdata", rsp_rdata, 32'h0000_1234);
        idle(1'b0, 1'b1);

        // Slave error, response stalled five cycles with a competing command present.
        step(1'b1, 1'b0, 32'h3000_0008, 32'h0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
        chk("e_err", {30'b0, rsp_err, rsp_timeout}, 32'h2);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 32'h3000_0abc, 32'h9, 1'b1, 0, 1'b0, 1'b0, 1'b0);
            chk("e_hold", {30'b0, rsp_valid, cmd_ready}, 32'h2);
        end
        idle(1'b0, 1'b1);

        // Reset during ACCESS.
        step(1'b1, 1'b0, 32'h3000_0010, 32'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        chk("rm_apb", {30'b0, PSEL, PENABLE}, 32'h0);
        chk("rm_ready", {31'b0, cmd_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 1'b1);
            chk("rm_no_rsp", {31'b0, rsp_valid}, 32'h0);
        end

        // Stuck PREADY.
        step(1'b1, 1'b0, 32'h3000_0020, 32'h0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(1'b0, 1'b1);
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < TCYC - 1; i++) begin
            idle(1'b0, 1'b0);
            chk("to_wait", {30'b0, PSEL, rsp_valid}, 32'h2);
        end
        idle(1'b0, 1'b0);
        chk("to_abort", {29'b0, rsp_valid, rsp_err, rsp_timeout}, 32'h7);
        chk("to_rdata", rsp_rdata, 32'h0);
        chk("to_apb", {30'b0, PSEL, PENABLE}, 32'h0);
`else
        for (int i = 0; i < 20; i++) begin
            idle(1'b0, 1'b0);
            chk("nt_wait", {29'b0, PSEL, PENABLE, rsp_valid}, 32'h6);
        end
        step(1'b0, 1'b0, 0, 0, 1'b1, 32'hab, 1'b0, 1'b0, 1'b0);
`endif
        idle(1'b0, 1'b1);

        // Back-to-back commands.
        step(1'b1, 1'b1, 32'h3000_0000, 32'h5, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        chk("bb_rsp1", {31'b0, rsp_valid}, 32'h1);
        step(1'b1, 1'b0, 32'h3000_001c, 32'h0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        chk("bb_gap", {30'b0, PSEL, cmd_ready}, 32'h1);
        step(1'b1, 1'b0, 32'h3000_001c, 32'h0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        chk("bb_accept", {30'b0, PSEL, cmd_ready}, 32'h2);
        chk("bb_addr", PADDR, 32'h3000_001c);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                 ($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb3_master_bridge.md
Name: apb3_master_bridge

Overview:
Fabric-side APB3 initiator. Converts single read/write commands from fabric logic (sequencers, DMA helpers, test controllers) into APB3 SETUP/ACCESS transfers toward fabric APB3 slaves such as the ADC result/control register block. Returns read data and error status on a valid/ready response channel. One outstanding transfer at a time.

Parameters:
ADDR_W, 32, width of cmd_addr and PADDR
DATA_W, 32, width of write/read data and PWDATA/PRDATA
TIMEOUT_CYC, 255, max ACCESS cycles with PREADY low before abort; used only with APB_TIMEOUT_EN

Ports:
clk_i  in  1  single clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  high when the bridge can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  read data; 0 for writes and aborted transfers
rsp_err  out  1  PSLVERR seen or timeout abort
rsp_timeout  out  1  transfer aborted by timeout
PADDR  out  ADDR_W  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Clock clk_i; reset rst_i is synchronous and active-high.
- FSM states IDLE, SETUP, ACCESS, RESP. Reset -> IDLE.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0. cmd_ready=1 after reset.
- cmd_ready = (state==IDLE), registered-state decode, no combinational path from cmd_valid.
- IDLE: on cmd_valid&cmd_ready, latch cmd_write/addr/wdata into PWRITE/PADDR/PWDATA -> SETUP.
- SETUP: PSEL=1, PENABLE=0 -> ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1. If PREADY=1: capture PRDATA (reads only, else 0) into rsp_rdata, rsp_err=PSLVERR, rsp_timeout=0; drop PSEL/PENABLE; -> RESP. If PREADY=0: hold all APB outputs stable.
- RESP: rsp_valid=1, outputs held until rsp_valid&rsp_ready -> IDLE, rsp_valid=0.
- Latency: command accepted cycle T; SETUP T+1; ACCESS T+2; zero-wait PREADY gives rsp_valid at T+3. Minimum 4 cycles per transfer with rsp_ready tied high.
- PADDR/PWRITE/PWDATA stable from SETUP through end of ACCESS; hold last value while PSEL=0.
- cmd_addr low bits passed unchanged; no alignment checks.
- PSLVERR/PRDATA ignored outside ACCESS&PREADY.
- rst_i mid-transfer: APB outputs return to reset values next cycle, no response issued, pending command dropped.
- cmd_valid while busy: ignored (not accepted); command source must hold it.

Optional Feature:
APB_TIMEOUT_EN. Defined: 16-bit wait counter cleared on SETUP, increments each ACCESS cycle with PREADY=0; when it reaches TIMEOUT_CYC while PREADY still 0, abort: PSEL/PENABLE=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1, -> RESP. PREADY=1 on the same cycle as the limit wins (normal completion). Undefined: no counter, ACCESS waits indefinitely, rsp_timeout tied 0.

Decomposition:
- Package apb3_pkg: FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3), default widths, timeout counter width (16).
- One natural sub-module: apb3_wait_timer (counter + limit compare), instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write cmd addr 0x3000_0100 data 0x1, PREADY=1 -> PSEL at T+1, PENABLE at T+2, PWRITE=1, PWDATA=0x1; rsp_valid T+3, rsp_err=0, rsp_rdata=0.
- Read 0x3000_0004, PREADY low 3 ACCESS cycles then high with PRDATA=0x0000_1234 -> APB outputs stable throughout; rsp_rdata=0x0000_1234 after PREADY.
- Read with PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0; rsp_valid held 5 cycles while rsp_ready=0, cmd_ready=0 meanwhile.
- Assert rst_i during ACCESS -> next cycle PSEL=PENABLE=0, rsp_valid never asserts, cmd_ready=1.
- APB_TIMEOUT_EN, TIMEOUT_CYC=8, PREADY stuck 0 -> abort after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0; without macro bridge remains in ACCESS.
- Back-to-back cmds 0x3000_0000 then 0x3000_001c with rsp_ready=1 -> second accepted exactly one cycle after first response handshake, PSEL low in between.
